// File: rtl/vga_score_render_pkg.sv
// ============================================================================
// Module   : vga_score_render_pkg
// Purpose  : Shared types, command encodings, colours and layout for the
//            two-team scoreboard renderer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_score_render_pkg;

  localparam logic [1:0] c_OP_INC     = 2'b00;
  localparam logic [1:0] c_OP_DEC     = 2'b01;
  localparam logic [1:0] c_OP_CLR     = 2'b10;
  localparam logic [1:0] c_OP_CLR_ALL = 2'b11;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t c_COL_A   = '{r: 4'hF, g: 4'h0, b: 4'h0};
  localparam rgb_t c_COL_B   = '{r: 4'h0, g: 4'h0, b: 4'hF};
  localparam rgb_t c_COL_DIV = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t c_COL_OFF = '{r: 4'h0, g: 4'h0, b: 4'h0};

  localparam int c_X_A     = 192;
  localparam int c_X_B     = 376;
  localparam int c_Y_TOP   = 64;
  localparam int c_DIG_W   = 32;
  localparam int c_DIG_H   = 64;
  localparam int c_DIG_GAP = 8;
  localparam int c_SEG_T   = 6;
  localparam logic [9:0] c_DIV_X0 = 10'd318;
  localparam logic [9:0] c_DIV_X1 = 10'd321;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } cmd_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic bcd2_t bcd_inc(input bcd2_t s);
    bcd2_t n;
    n = s;
    if (s.tens == 4'd9 && s.units == 4'd9) begin
      n = s;
    end else if (s.units == 4'd9) begin
      n.units = 4'd0;
      n.tens  = s.tens + 4'd1;
    end else begin
      n.units = s.units + 4'd1;
    end
    return n;
  endfunction

  function automatic bcd2_t bcd_dec(input bcd2_t s);
    bcd2_t n;
    n = s;
    if (s.tens == 4'd0 && s.units == 4'd0) begin
      n = s;
    end else if (s.units == 4'd0) begin
      n.units = 4'd9;
      n.tens  = s.tens - 4'd1;
    end else begin
      n.units = s.units - 4'd1;
    end
    return n;
  endfunction

  // sel marks whether this team is the one addressed by the command
  function automatic bcd2_t next_score(input bcd2_t s, input logic [1:0] op, input logic sel);
    bcd2_t n;
    n = s;
    case (op)
      c_OP_INC: if (sel) n = bcd_inc(s);
      c_OP_DEC: if (sel) n = bcd_dec(s);
      c_OP_CLR: if (sel) n = '0;
      default:  n = '0;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_score_render_seg7_decode.sv
// ============================================================================
// Module   : seg7_decode
// Purpose  : BCD digit to seven-segment enables, bit 0 = a ... bit 6 = g.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // '1' is drawn on the left column (e,f) so a leading tens '1' hugs its box edge
  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h30;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vga_score_render.sv
// ============================================================================
// Module   : vga_score_render
// Purpose  : Two-team BCD scoreboard with command port, tear-free frame copy
//            and a 2-stage seven-segment pixel renderer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_score_render
  import vga_score_render_pkg::*;
#(
  parameter int X_A     = c_X_A,
  parameter int X_B     = c_X_B,
  parameter int Y_TOP   = c_Y_TOP,
  parameter int DIG_W   = c_DIG_W,
  parameter int DIG_H   = c_DIG_H,
  parameter int DIG_GAP = c_DIG_GAP,
  parameter int SEG_T   = c_SEG_T
) (
  input  logic       clk_vga,
  input  logic       rst_vga,
  input  logic       h_out_vga,
  input  logic       v_out_vga,
  input  logic [9:0] horizontal_x_vga,
  input  logic [9:0] vertical_y_vga,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_team,
  input  logic [1:0] cmd_op,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync_o,
  output logic       vsync_o
);

  localparam int c_LXW = $clog2(DIG_W);
  localparam int c_LYW = $clog2(DIG_H);

  // box order: A tens, A units, B tens, B units
  localparam logic [9:0] c_BOX_X [4] = '{10'(X_A), 10'(X_A + DIG_W + DIG_GAP),
                                         10'(X_B), 10'(X_B + DIG_W + DIG_GAP)};
  localparam logic [9:0] c_Y0 = 10'(Y_TOP);
  localparam logic [9:0] c_DW = 10'(DIG_W);
  localparam logic [9:0] c_DH = 10'(DIG_H);

  localparam logic [c_LXW-1:0] c_LX_IN0  = c_LXW'(SEG_T - 2);
  localparam logic [c_LXW-1:0] c_LX_IN1  = c_LXW'(DIG_W - SEG_T + 1);
  localparam logic [c_LXW-1:0] c_LX_L1   = c_LXW'(SEG_T - 1);
  localparam logic [c_LXW-1:0] c_LX_R    = c_LXW'(DIG_W - SEG_T);
  localparam logic [c_LYW-1:0] c_LY_TOP1 = c_LYW'(SEG_T - 1);
  localparam logic [c_LYW-1:0] c_LY_UP0  = c_LYW'(SEG_T - 2);
  localparam logic [c_LYW-1:0] c_LY_UP1  = c_LYW'(DIG_H / 2 - 1);
  localparam logic [c_LYW-1:0] c_LY_LO0  = c_LYW'(DIG_H / 2);
  localparam logic [c_LYW-1:0] c_LY_LO1  = c_LYW'(DIG_H - SEG_T + 1);
  localparam logic [c_LYW-1:0] c_LY_BOT0 = c_LYW'(DIG_H - SEG_T);
  localparam logic [c_LYW-1:0] c_LY_MID0 = c_LYW'(DIG_H / 2 - SEG_T / 2);
  localparam logic [c_LYW-1:0] c_LY_MID1 = c_LYW'(DIG_H / 2 + SEG_T / 2 - 1);

  cmd_state_t r_state;
  cmd_state_t w_state_nxt;
  logic       r_team;
  logic [1:0] r_op;
  bcd2_t      r_shadow_a;
  bcd2_t      r_shadow_b;
  bcd2_t      r_disp_a;
  bcd2_t      r_disp_b;
  logic       r_vs_prev;
  logic       w_vs_rise;

  always_ff @(posedge clk_vga) begin
    if (rst_vga) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_vs_rise = v_out_vga & ~r_vs_prev;

  // frame copy reads the shadow before any same-cycle update lands
  always_ff @(posedge clk_vga) begin
    if (rst_vga) begin
      r_team     <= 1'b0;
      r_op       <= 2'b00;
      r_shadow_a <= '0;
      r_shadow_b <= '0;
      r_disp_a   <= '0;
      r_disp_b   <= '0;
      r_vs_prev  <= 1'b0;
    end else begin
      r_vs_prev <= v_out_vga;
      if (w_vs_rise) begin
        r_disp_a <= r_shadow_a;
        r_disp_b <= r_shadow_b;
      end
      if (cmd_valid && cmd_ready) begin
        r_team <= cmd_team;
        r_op   <= cmd_op;
      end
      if (r_state == ST_UPDATE) begin
        r_shadow_a <= next_score(r_shadow_a, r_op, ~r_team);
        r_shadow_b <= next_score(r_shadow_b, r_op, r_team);
      end
    end
  end

  logic             w_nz;
  logic             w_in_y;
  logic [3:0]       w_box_hit;
  logic [9:0]       w_dx [4];
  logic             w_hit;
  logic [1:0]       w_box;
  logic [c_LXW-1:0] w_lx;
  logic [c_LYW-1:0] w_ly;

  assign w_nz   = (horizontal_x_vga != 10'd0) && (vertical_y_vga != 10'd0);
  assign w_in_y = (vertical_y_vga >= c_Y0) && (vertical_y_vga < c_Y0 + c_DH);

  for (genvar i = 0; i < 4; i++) begin : g_box
    assign w_dx[i]      = horizontal_x_vga - c_BOX_X[i];
    assign w_box_hit[i] = w_nz && w_in_y && (horizontal_x_vga >= c_BOX_X[i]) &&
                          (horizontal_x_vga < c_BOX_X[i] + c_DW);
  end

  always_comb begin
    w_hit = 1'b0;
    w_box = 2'd0;
    w_lx  = '0;
    w_ly  = c_LYW'(vertical_y_vga - c_Y0);
    for (int i = 0; i < 4; i++) begin
      if (w_box_hit[i]) begin
        w_hit = 1'b1;
        w_box = 2'(i);
        w_lx  = c_LXW'(w_dx[i]);
      end
    end
  end

  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_hs1;
  logic             r_vs1;
  logic             r_hit;
  logic [1:0]       r_box;
  logic [c_LXW-1:0] r_lx;
  logic [c_LYW-1:0] r_ly;

  always_ff @(posedge clk_vga) begin
    if (rst_vga) begin
      r_x   <= '0;
      r_y   <= '0;
      r_hs1 <= 1'b0;
      r_vs1 <= 1'b0;
      r_hit <= 1'b0;
      r_box <= 2'd0;
      r_lx  <= '0;
      r_ly  <= '0;
    end else begin
      r_x   <= horizontal_x_vga;
      r_y   <= vertical_y_vga;
      r_hs1 <= h_out_vga;
      r_vs1 <= v_out_vga;
      r_hit <= w_hit;
      r_box <= w_box;
      r_lx  <= w_lx;
      r_ly  <= w_ly;
    end
  end

  logic [3:0] w_digit;
  logic [6:0] w_seg;
  logic [6:0] w_region;
  logic       w_lx_mid;
  logic       w_lx_l;
  logic       w_lx_r;
  logic       w_ly_up;
  logic       w_ly_lo;
  logic       w_lit;
  logic       w_div;
  logic       w_blank;
  rgb_t       w_col;

  always_comb begin
    w_digit = 4'd0;
    case (r_box)
      2'd0:    w_digit = r_disp_a.tens;
      2'd1:    w_digit = r_disp_a.units;
      2'd2:    w_digit = r_disp_b.tens;
      default: w_digit = r_disp_b.units;
    endcase
  end

  seg7_decode u_seg7 (
    .digit (w_digit),
    .seg   (w_seg)
  );

  assign w_lx_mid = (r_lx >= c_LX_IN0) && (r_lx <= c_LX_IN1);
  assign w_lx_l   = (r_lx <= c_LX_L1);
  assign w_lx_r   = (r_lx >= c_LX_R);
  assign w_ly_up  = (r_ly >= c_LY_UP0) && (r_ly <= c_LY_UP1);
  assign w_ly_lo  = (r_ly >= c_LY_LO0) && (r_ly <= c_LY_LO1);

  assign w_region = {
    w_lx_mid && (r_ly >= c_LY_MID0) && (r_ly <= c_LY_MID1),
    w_lx_l && w_ly_up,
    w_lx_l && w_ly_lo,
    w_lx_mid && (r_ly >= c_LY_BOT0),
    w_lx_r && w_ly_lo,
    w_lx_r && w_ly_up,
    w_lx_mid && (r_ly <= c_LY_TOP1)
  };

  // even box index = tens digit, blanked when zero
  assign w_lit   = r_hit && !(!r_box[0] && w_digit == 4'd0) && |(w_seg & w_region);
  assign w_div   = (r_x >= c_DIV_X0) && (r_x <= c_DIV_X1);
  assign w_blank = (r_x == 10'd0) || (r_y == 10'd0);

  always_comb begin
    w_col = c_COL_OFF;
    if (!w_blank) begin
      if (w_div)      w_col = c_COL_DIV;
      else if (w_lit) w_col = r_box[1] ? c_COL_B : c_COL_A;
    end
  end

  rgb_t r_col;
  logic r_hs2;
  logic r_vs2;

  always_ff @(posedge clk_vga) begin
    if (rst_vga) begin
      r_col <= c_COL_OFF;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
    end else begin
      r_col <= w_col;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
    end
  end

  assign vga_r   = r_col.r;
  assign vga_g   = r_col.g;
  assign vga_b   = r_col.b;
  assign hsync_o = r_hs2;
  assign vsync_o = r_vs2;

endmodule

`default_nettype wire

// File: tb/tb_vga_score_render.sv
// ============================================================================
// Module   : tb_vga_score_render
// Purpose  : Self-checking bench: integer-score reference model with per-cycle
//            compare, plus literal pixel probes for the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_score_render;

  logic       clk_vga = 1'b0;
  logic       rst_vga = 1'b1;
  logic       h_out_vga = 1'b1;
  logic       v_out_vga = 1'b1;
  logic [9:0] horizontal_x_vga = '0;
  logic [9:0] vertical_y_vga = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_team = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync_o, vsync_o;

  always #20 clk_vga = ~clk_vga;

  vga_score_render dut (
    .clk_vga          (clk_vga),
    .rst_vga          (rst_vga),
    .h_out_vga        (h_out_vga),
    .v_out_vga        (v_out_vga),
    .horizontal_x_vga (horizontal_x_vga),
    .vertical_y_vga   (vertical_y_vga),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_team         (cmd_team),
    .cmd_op           (cmd_op),
    .vga_r            (vga_r),
    .vga_g            (vga_g),
    .vga_b            (vga_b),
    .hsync_o          (hsync_o),
    .vsync_o          (vsync_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (integer scores, pixel geometry) ----------
  function automatic string glyph_of(input int d);
    case (d)
      0: return "abcdef";
      1: return "ef";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      9: return "abcdfg";
      default: return "";
    endcase
  endfunction

  function automatic bit seg_on(input byte c, input int lx, input int ly);
    case (c)
      "a": return ly <= 5 && lx >= 4 && lx <= 27;
      "b": return lx >= 26 && ly >= 4 && ly <= 31;
      "c": return lx >= 26 && ly >= 32 && ly <= 59;
      "d": return ly >= 58 && lx >= 4 && lx <= 27;
      "e": return lx <= 5 && ly >= 32 && ly <= 59;
      "f": return lx <= 5 && ly >= 4 && ly <= 31;
      "g": return ly >= 29 && ly <= 34 && lx >= 4 && lx <= 27;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] render(input int x, input int y, input int sa, input int sb);
    logic [11:0] col;
    int x0, team, d, sc;
    string g;
    col = 12'h000;
    if (x != 0 && y != 0) begin
      if (x >= 318 && x <= 321) col = 12'hFFF;
      for (int b = 0; b < 4; b++) begin
        x0 = ((b < 2) ? 192 : 376) + (b % 2) * 40;
        if (x >= x0 && x < x0 + 32 && y >= 64 && y < 128) begin
          team = b / 2;
          sc   = team ? sb : sa;
          d    = (b % 2 == 0) ? sc / 10 : sc % 10;
          if (!(b % 2 == 0 && d == 0)) begin
            g = glyph_of(d);
            for (int k = 0; k < g.len(); k++)
              if (seg_on(g[k], x - x0, y - 64)) col = team ? 12'h00F : 12'hF00;
          end
        end
      end
    end
    return col;
  endfunction

  int          m_score [2];
  int          m_disp  [2];
  bit          m_busy, m_pteam, m_prev_v, m_live;
  int          m_pop;
  int          m_px, m_py;
  bit          m_phs, m_pvs;
  logic [11:0] e_col;
  bit          e_hs, e_vs;

  initial m_live = 1'b0;

  always @(posedge clk_vga) begin
    if (rst_vga) begin
      m_live = 1'b1;
      m_score[0] = 0; m_score[1] = 0; m_disp[0] = 0; m_disp[1] = 0;
      m_busy = 1'b0; m_pteam = 1'b0; m_pop = 0; m_prev_v = 1'b0;
      m_px = 0; m_py = 0; m_phs = 1'b0; m_pvs = 1'b0;
      e_col = 12'h000; e_hs = 1'b0; e_vs = 1'b0;
    end else begin
      e_col = render(m_px, m_py, m_disp[0], m_disp[1]);
      e_hs  = m_phs;
      e_vs  = m_pvs;
      if (v_out_vga && !m_prev_v) begin
        m_disp[0] = m_score[0];
        m_disp[1] = m_score[1];
      end
      if (m_busy) begin
        case (m_pop)
          0: m_score[m_pteam] = (m_score[m_pteam] < 99) ? m_score[m_pteam] + 1 : 99;
          1: m_score[m_pteam] = (m_score[m_pteam] > 0) ? m_score[m_pteam] - 1 : 0;
          2: m_score[m_pteam] = 0;
          default: begin m_score[0] = 0; m_score[1] = 0; end
        endcase
        m_busy = 1'b0;
      end else if (cmd_valid) begin
        m_busy  = 1'b1;
        m_pteam = cmd_team;
        m_pop   = int'(cmd_op);
      end
      m_prev_v = v_out_vga;
      m_px  = int'(horizontal_x_vga);
      m_py  = int'(vertical_y_vga);
      m_phs = h_out_vga;
      m_pvs = v_out_vga;
    end
  end

  always @(negedge clk_vga) begin
    if (m_live) begin
      chk("rgb",   {vga_r, vga_g, vga_b}, e_col);
      chk("hsync", 12'(hsync_o), 12'(e_hs));
      chk("vsync", 12'(vsync_o), 12'(e_vs));
      chk("ready", 12'(cmd_ready), 12'(!m_busy));
    end
  end

  // ---------------- stimulus --------------------------------------------------
  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic drive_rand();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel < 6) begin
      horizontal_x_vga = 10'($urandom_range(180, 460));
      vertical_y_vga   = 10'($urandom_range(55, 135));
    end else if (sel == 6) begin
      horizontal_x_vga = 10'($urandom_range(0, 1) ? 0 : $urandom_range(1, 639));
      vertical_y_vga   = 10'($urandom_range(0, 1) ? 0 : $urandom_range(1, 479));
    end else begin
      horizontal_x_vga = 10'($urandom_range(0, 639));
      vertical_y_vga   = 10'($urandom_range(0, 479));
    end
    h_out_vga = 1'($urandom_range(0, 1));
  endtask

  task automatic tick_rand();
    drive_rand();
    step();
  endtask

  task automatic frame();
    horizontal_x_vga = '0;
    vertical_y_vga   = '0;
    v_out_vga = 1'b0;
    repeat (3) step();
    v_out_vga = 1'b1;
    repeat (2) step();
  endtask

  task automatic probe(input int x, input int y, input logic [11:0] exp, input string nm);
    horizontal_x_vga = 10'(x);
    vertical_y_vga   = 10'(y);
    step();
    horizontal_x_vga = '0;
    vertical_y_vga   = '0;
    step();
    chk(nm, {vga_r, vga_g, vga_b}, exp);
  endtask

  task automatic send_cmd(input bit team, input logic [1:0] op);
    int n;
    cmd_team  = team;
    cmd_op    = op;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 8) begin
      tick_rand();
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_wait: cmd_ready=%b after 8 cycles, expected 1", cmd_ready);
    end
    tick_rand();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rdy_pat;
    int         hs_cnt, r;
    logic [1:0] op;

    rst_vga = 1'b1;
    repeat (3) step();
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_hsync", 12'(hsync_o), 12'h0);
    chk("rst_vsync", 12'(vsync_o), 12'h0);
    rst_vga = 1'b0;
    step();
    chk("rst_ready", 12'(cmd_ready), 12'h1);

    // initial frame: 00 / 00
    frame();
    probe(320, 100, 12'hFFF, "div_lit");
    probe(319, 0,   12'h000, "div_y0_black");
    probe(194, 70,  12'h000, "a_tens_blank");
    probe(386, 66,  12'h000, "b_tens_blank");
    probe(242, 66,  12'hF00, "a_units_0_a");
    probe(426, 66,  12'h00F, "b_units_0_a");
    probe(100, 100, 12'h000, "background");
    repeat (1500) tick_rand();

    // 10 x inc on A -> 10 after next frame
    repeat (10) send_cmd(1'b0, 2'b00);
    tick_rand();
    probe(194, 70, 12'h000, "a10_before_frame");
    frame();
    probe(194, 70, 12'hF00, "a10_tens_f");
    probe(242, 66, 12'hF00, "a10_units_a");

    // dec on 10 -> 09; dec on 00 stays 00
    send_cmd(1'b0, 2'b01);
    frame();
    probe(194, 70, 12'h000, "a09_tens_blank");
    probe(242, 95, 12'hF00, "a09_units_g");
    send_cmd(1'b0, 2'b10);
    send_cmd(1'b0, 2'b01);
    frame();
    probe(242, 66, 12'hF00, "a00_units_a");
    probe(242, 95, 12'h000, "a00_units_g_off");

    // 100 x inc on B saturates at 99, then dec -> 98
    repeat (100) send_cmd(1'b1, 2'b00);
    frame();
    probe(386, 66,  12'h00F, "b99_tens_a");
    probe(418, 104, 12'h000, "b99_units_e_off");
    send_cmd(1'b1, 2'b01);
    frame();
    probe(418, 104, 12'h00F, "b98_units_e");

    // UPDATE lands on the vsync rising edge: old value shown this frame
    horizontal_x_vga = '0;
    vertical_y_vga   = '0;
    v_out_vga = 1'b0;
    repeat (2) step();
    cmd_team  = 1'b0;
    cmd_op    = 2'b00;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    v_out_vga = 1'b1;
    step();
    probe(242, 66, 12'hF00, "coinc_old_value");
    frame();
    probe(242, 66, 12'h000, "coinc_next_frame");

    // cmd_valid held 4 cycles -> ready 1,0,1,0 and 2 handshakes
    step();
    cmd_team  = 1'b0;
    cmd_op    = 2'b00;
    cmd_valid = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      rdy_pat[3-i] = cmd_ready;
      if (cmd_ready) hs_cnt++;
      tick_rand();
    end
    cmd_valid = 1'b0;
    chk("ready_pattern", 12'(rdy_pat), 12'hA);
    chk("handshake_cnt", 12'(hs_cnt), 12'd2);
    frame();
    probe(242, 95,  12'hF00, "a03_units_g");
    probe(234, 104, 12'h000, "a03_units_e_off");

    // reset while in UPDATE discards the command
    step();
    cmd_op    = 2'b00;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    rst_vga = 1'b1;
    step();
    rst_vga = 1'b0;
    step();
    frame();
    probe(242, 66, 12'hF00, "rst_mid_units_0");
    probe(194, 70, 12'h000, "rst_mid_tens_blank");

    // randomized commands, pixels and frames
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 19);
      op = (r < 11) ? 2'b00 : (r < 17) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      send_cmd(1'($urandom_range(0, 1)), op);
      repeat ($urandom_range(0, 3)) tick_rand();
      if ($urandom_range(0, 5) == 0) frame();
    end
    frame();
    repeat (500) tick_rand();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_score_render.md
VGA_SCORE_RENDER -- requirements
Module: vga_score_render

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high: clk_vga and rst_vga.
REQ-002 SHALL have port clk_vga, input, 1 bit: pixel clock (25 MHz).
REQ-003 SHALL have port rst_vga, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have ports h_out_vga / v_out_vga, input, 1 bit each: sync from the timing generator.
REQ-005 SHALL have ports horizontal_x_vga / vertical_y_vga, input, 10 bits each: visible position from the timing generator; 0 during blanking.
REQ-006 SHALL have port cmd_valid, input, 1 bit: score command offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_team, input, 1 bit: 0 = team A, 1 = team B.
REQ-009 SHALL have port cmd_op, input, 2 bits: 00 inc, 01 dec, 10 clear team, 11 clear both.
REQ-010 SHALL have ports vga_r / vga_g / vga_b, output, 4 bits each: pixel colour.
REQ-011 SHALL have ports hsync_o / vsync_o, output, 1 bit each: sync delayed to align with the colour outputs.
REQ-012 SHALL have parameters X_A = 192, X_B = 376, Y_TOP = 64, DIG_W = 32, DIG_H = 64, DIG_GAP = 8, SEG_T = 6.

Function
REQ-013 SHALL keep per-team shadow scores as 2-digit BCD (tens, units), range 0..99.
REQ-014 SHALL run a command FSM with states IDLE and UPDATE; IDLE->UPDATE on handshake, UPDATE->IDLE after exactly one cycle; cmd_ready = 1 only in IDLE.
REQ-015 SHALL latch team and op at the handshake and apply them to the shadow score in UPDATE.
REQ-016 SHALL handle inc at 99 by saturating at 99 and dec at 0 by saturating at 0; unit 9->0 SHALL carry into tens, and unit 0->9 SHALL borrow from tens.
REQ-017 SHALL copy both shadow scores to display scores only on the cycle where a v_out_vga rising edge is detected (1-cycle registered compare), so each frame is tear-free.
REQ-018 SHALL, when an UPDATE and a frame-copy fall on the same cycle, copy the pre-update shadow value; the update appears the next frame.
REQ-019 SHALL draw digit boxes DIG_W x DIG_H at y Y_TOP..Y_TOP+63, as follows: team A tens at x 192..223 and units at 232..263; team B tens at 376..407 and units at 416..447.
REQ-020 SHALL use these segments in box-local coordinates (lx, ly): a ly0-5 lx4-27; b lx26-31 ly4-31; c lx26-31 ly32-59; d ly58-63 lx4-27; e lx0-5 ly32-59; f lx0-5 ly4-31; g ly29-34 lx4-27.
REQ-021 SHALL colour a lit segment F,0,0 for team A and 0,0,F for team B; SHALL colour the divider F,F,F at x 318..321 where y ≠ 0; everything else SHALL be 0,0,0.
REQ-022 SHALL blank a tens digit of 0 (no leading zero).
REQ-023 SHALL render any pixel with x = 0 or y = 0 black, because that is the blanking encoding.
REQ-024 SHALL be a 2-stage pipeline: stage 1 registers x, y, syncs and box-hit/local coordinates; stage 2 registers the colour. Colour latency SHALL be 2 cycles from the input position.
REQ-025 SHALL delay hsync_o and vsync_o by exactly 2 cycles.

Reset
REQ-026 SHALL, on rst_vga: FSM = IDLE, cmd_ready = 1 on the cycle after reset release, shadow and display scores = 00, colour outputs = 0, hsync_o and vsync_o = 0, pipeline registers and edge detector = 0.
REQ-027 SHALL have reset mid-UPDATE discard the pending command; no partial score change is allowed.

Structure
REQ-028 SHALL place in the shared package: the cmd_op encodings, the team colour constants, the layout parameters and the FSM state encoding.
REQ-029 SHALL instantiate one sub-module, seg7_decode: combinational BCD digit -> 7 segment enables (a..g); non-BCD inputs give all segments off.

Verification
REQ-030 SHALL cover: reset, then one full 800x525 frame -> display 00 and 00; only the divider is lit; both tens digits are blank.
REQ-031 SHALL cover: 10 x inc on team A -> display A = 10 after the next vsync rising edge; pixel (194, 70) (segment f of the tens digit) = F,0,0 two cycles after the input position.
REQ-032 SHALL cover: 100 x inc on team B -> B = 99 (saturated); 1 further dec -> 98.
REQ-033 SHALL cover: a dec on score 00 -> stays 00; a dec on 10 -> 09.
REQ-034 SHALL cover: a command issued so that UPDATE coincides with the vsync edge -> the new value is not shown in that frame and is shown in the next.
REQ-035 SHALL cover: cmd_valid held high for 4 cycles -> exactly 2 handshakes (ready pattern 1,0,1,0); hsync_o equals h_out_vga delayed by 2 cycles throughout.
